// File: rtl/joy_serial_multi.sv
// ---------------------------------------------------------------------------
// joy_serial_multi
//   Serial joystick chain reader for PLAYERS pads of BITS buttons each.
//   It drives a parallel-load shift-register chain and shifts in TOTAL bits
//   per frame. Each frame is debounced across DEBOUNCE identical frames. The
//   result is polarity-corrected so that pressed = 1, and frame_valid pulses
//   whenever joystick is written.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   enable       in   1 = scan the chain; 0 = idle lines, clear outputs
//   joy_clk      out  shift clock to the chain (idles high)
//   joy_load     out  parallel-load strobe, active low (idles high)
//   joy_data     in   serial data from the chain (asynchronous)
//   joystick     out  debounced buttons; player p at [p*BITS +: BITS]
//   frame_valid  out  1-clk pulse when joystick is (re)written
// ---------------------------------------------------------------------------
module joy_serial_multi #(
  parameter int CLK_DIV    = 24,
  parameter int PLAYERS    = 2,
  parameter int BITS       = 12,
  parameter int DEBOUNCE   = 2,
  parameter int GAP_TICKS  = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    joy_clk,
  output logic                    joy_load,
  input  logic                    joy_data,
  output logic [PLAYERS*BITS-1:0] joystick,
  output logic                    frame_valid
);

  localparam int TOTAL = PLAYERS * BITS;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GW    = $clog2(GAP_TICKS + 1);
  localparam int SW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

  // Tick divider: runs only while enabled, restarts from zero on enable rise.
  logic [DW-1:0] div_reg;
  logic          tick;

  assign tick = enable && (div_reg == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) div_reg <= '0;
    else                          div_reg <= div_reg + DW'(1);
  end

  // Two-flop synchroniser on the asynchronous chain input.
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], joy_data};
  end

  state_t            state_reg, state_next;
  logic              joy_clk_reg, joy_clk_next;
  logic              joy_load_reg, joy_load_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic [GW-1:0]     cnt_reg, cnt_next;      // LOAD and GAP tick counter
  logic [TOTAL-1:0]  raw_reg, raw_next;
  logic [TOTAL-1:0]  prev_reg, prev_next;
  logic              prev_ok_reg, prev_ok_next; // prev holds a real frame
  logic [SW-1:0]     stable_reg, stable_next;
  logic [TOTAL-1:0]  joy_reg, joy_next;
  logic              fv_reg, fv_next;
  logic [TOTAL-1:0]  cur;

  assign cur = (ACTIVE_LOW != 0) ? ~raw_reg : raw_reg;

  always_comb begin
    state_next    = state_reg;
    joy_clk_next  = joy_clk_reg;
    joy_load_next = joy_load_reg;
    bit_next      = bit_reg;
    cnt_next      = cnt_reg;
    raw_next      = raw_reg;
    prev_next     = prev_reg;
    prev_ok_next  = prev_ok_reg;
    stable_next   = stable_reg;
    joy_next      = joy_reg;
    fv_next       = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          state_next    = LOAD;
          joy_load_next = 1'b0;
          cnt_next      = '0;
        end
        LOAD: begin
          if (cnt_reg == GW'(1)) begin
            state_next    = SHIFT;
            joy_load_next = 1'b1;
            bit_next      = '0;
          end else begin
            cnt_next = cnt_reg + GW'(1);
          end
        end
        SHIFT: begin
          // joy_clk high means the next tick is the falling half of a bit.
          if (joy_clk_reg) begin
            joy_clk_next = 1'b0;
          end else begin
            raw_next[bit_reg] = sync_reg[1];
            joy_clk_next      = 1'b1;
            if (bit_reg == BW'(TOTAL - 1)) state_next = LATCH;
            else                           bit_next   = bit_reg + BW'(1);
          end
        end
        LATCH: begin
          if (!prev_ok_reg || (cur != prev_reg))     stable_next = '0;
          else if (stable_reg == SW'(DEBOUNCE - 1))  stable_next = stable_reg;
          else                                       stable_next = stable_reg + SW'(1);
          prev_next    = cur;
          prev_ok_next = 1'b1;
          if (stable_next == SW'(DEBOUNCE - 1)) begin
            joy_next = cur;
            fv_next  = 1'b1;
          end
          state_next = GAP;
          cnt_next   = '0;
        end
        GAP: begin
          if (cnt_reg == GW'(GAP_TICKS - 1)) begin
            state_next    = LOAD;
            joy_load_next = 1'b0;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + GW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Dropping enable behaves like reset: the partial frame and the debounce
  // history are discarded so the next frame starts from a clean slate.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_reg    <= IDLE;
      joy_clk_reg  <= 1'b1;
      joy_load_reg <= 1'b1;
      bit_reg      <= '0;
      cnt_reg      <= '0;
      raw_reg      <= '0;
      prev_reg     <= '0;
      prev_ok_reg  <= 1'b0;
      stable_reg   <= '0;
      joy_reg      <= '0;
      fv_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      joy_clk_reg  <= joy_clk_next;
      joy_load_reg <= joy_load_next;
      bit_reg      <= bit_next;
      cnt_reg      <= cnt_next;
      raw_reg      <= raw_next;
      prev_reg     <= prev_next;
      prev_ok_reg  <= prev_ok_next;
      stable_reg   <= stable_next;
      joy_reg      <= joy_next;
      fv_reg       <= fv_next;
    end
  end

  assign joy_clk     = joy_clk_reg;
  assign joy_load    = joy_load_reg;
  assign joystick    = joy_reg;
  assign frame_valid = fv_reg;

endmodule

// File: tb/tb_joy_serial_multi.sv
// ---------------------------------------------------------------------------
// tb_joy_serial_multi
//   Directed bench for joy_serial_multi. There are three instances:
//     a : defaults (2 x 12 buttons, active low, DEBOUNCE=2)
//     b : ACTIVE_LOW=0, PLAYERS=1, BITS=8, DEBOUNCE=1
//     c : CLK_DIV=1, PLAYERS=1, BITS=4, with its own reset
//   Each instance has a small shift-register chain model. The model reloads
//   when joy_load falls and advances on each joy_clk rise.
// ---------------------------------------------------------------------------
module tb_joy_serial_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rst_c;
  logic en_a, en_b, en_c;
  logic jclk_a, jload_a, jdata_a, fv_a;
  logic jclk_b, jload_b, jdata_b, fv_b;
  logic jclk_c, jload_c, jdata_c, fv_c;
  logic [23:0] joy_a;
  logic [7:0]  joy_b;
  logic [3:0]  joy_c;

  joy_serial_multi u_a (
    .clk(clk), .reset(reset), .enable(en_a), .joy_clk(jclk_a), .joy_load(jload_a),
    .joy_data(jdata_a), .joystick(joy_a), .frame_valid(fv_a));

  joy_serial_multi #(.ACTIVE_LOW(0), .PLAYERS(1), .BITS(8), .DEBOUNCE(1)) u_b (
    .clk(clk), .reset(reset), .enable(en_b), .joy_clk(jclk_b), .joy_load(jload_b),
    .joy_data(jdata_b), .joystick(joy_b), .frame_valid(fv_b));

  joy_serial_multi #(.CLK_DIV(1), .PLAYERS(1), .BITS(4)) u_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .joy_clk(jclk_c), .joy_load(jload_c),
    .joy_data(jdata_c), .joystick(joy_c), .frame_valid(fv_c));

  // Chain models. Instance a alternates between two patterns on odd and even frames.
  logic [23:0] pat0_a, pat1_a, cur_chain_a;
  int          idx_a, idx_b, idx_c, frame_no_a;
  logic [7:0]  chain_b;
  logic [3:0]  chain_c;

  initial begin
    idx_a = 0; idx_b = 0; idx_c = 0; frame_no_a = 0; cur_chain_a = '1;
  end

  always @(negedge jload_a) begin
    idx_a = 0;
    frame_no_a = frame_no_a + 1;
    cur_chain_a = frame_no_a[0] ? pat1_a : pat0_a;
  end
  always @(posedge jclk_a) if (jload_a === 1'b1) idx_a = idx_a + 1;
  always @(negedge jload_b) idx_b = 0;
  always @(posedge jclk_b) if (jload_b === 1'b1) idx_b = idx_b + 1;
  always @(negedge jload_c) idx_c = 0;
  always @(posedge jclk_c) if (jload_c === 1'b1) idx_c = idx_c + 1;

  assign jdata_a = (idx_a < 24) ? cur_chain_a[idx_a[4:0]] : 1'b1;
  assign jdata_b = (idx_b < 8)  ? chain_b[idx_b[2:0]]     : 1'b0;
  assign jdata_c = (idx_c < 4)  ? chain_c[idx_c[1:0]]     : 1'b0;

  // Activity monitors, sampled just after each active edge.
  int   lowcnt_a = 0, falls_a = 0, fvcnt_a = 0, fvcnt_b = 0, fvcnt_c = 0;
  logic prev_jclk_a = 1'b1;
  always @(posedge clk) begin
    #1;
    if (jload_a === 1'b0) lowcnt_a = lowcnt_a + 1;
    if (prev_jclk_a === 1'b1 && jclk_a === 1'b0) falls_a = falls_a + 1;
    prev_jclk_a = jclk_a;
    if (fv_a === 1'b1) fvcnt_a = fvcnt_a + 1;
    if (fv_b === 1'b1) fvcnt_b = fvcnt_b + 1;
    if (fv_c === 1'b1) fvcnt_c = fvcnt_c + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clocks until frame_valid of instance sel is seen; -1 on timeout.
  task automatic wait_fv(input int sel, input int max, output int cyc);
    logic hit;
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? fv_a : (sel == 1) ? fv_b : fv_c;
      if (hit === 1'b1) begin cyc = i; break; end
    end
  endtask

  // Clocks until joy_load of instance sel is seen low; -1 on timeout.
  task automatic wait_load(input int sel, input int max, output int cyc);
    logic ld;
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      ld = (sel == 0) ? jload_a : jload_c;
      if (ld === 1'b0) begin cyc = i; break; end
    end
  endtask

  int c, s_fv, s_low, s_falls, found;

  initial begin
    reset = 1'b1; rst_c = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    pat0_a = '1; pat1_a = '1; chain_b = 8'h00; chain_c = 4'h0;
    repeat (5) @(negedge clk);

    // 1: reset values, then 1000 clk idle with enable low.
    chk("rst_joy_clk",  {jclk_a, jclk_b, jclk_c}, 3'b111);
    chk("rst_joy_load", {jload_a, jload_b, jload_c}, 3'b111);
    chk("rst_joystick", {joy_a, joy_b, joy_c}, 36'h0);
    reset = 1'b0; rst_c = 1'b0;
    s_fv = fvcnt_a + fvcnt_b + fvcnt_c; s_low = lowcnt_a; s_falls = falls_a;
    repeat (1000) @(negedge clk);
    chk("idle_lines", {jclk_a, jload_a, jclk_c, jload_c}, 4'hF);
    chk("idle_joystick", {joy_a, joy_b, joy_c}, 36'h0);
    chk("idle_no_fv", fvcnt_a + fvcnt_b + fvcnt_c - s_fv, 0);
    chk("idle_no_activity", (lowcnt_a - s_low) + (falls_a - s_falls), 0);
    $display("step 1 idle done: joystick_a=%h", joy_a);

    // 2: defaults; P0=0xFFE, P1=0xFFF -> first update at end of frame 2.
    pat0_a = {12'hFFF, 12'hFFE}; pat1_a = pat0_a;
    s_fv = fvcnt_a; s_low = lowcnt_a; s_falls = falls_a;
    en_a = 1'b1;
    repeat (1300) @(negedge clk);
    chk("f1_no_update", joy_a, 24'h0);
    chk("f1_no_fv", fvcnt_a - s_fv, 0);
    wait_fv(0, 3000, c);
    chk("f2_fv_time", c, 1364);
    chk("f2_joystick", joy_a, 24'h000001);
    wait_fv(0, 3000, c);
    chk("f3_fv_period", c, 1416);
    chk("f3_joystick", joy_a, 24'h000001);
    chk("load_low_clks_3f", lowcnt_a - s_low, 144);
    chk("joy_clk_falls_3f", falls_a - s_falls, 72);
    chk("fv_pulses_3f", fvcnt_a - s_fv, 2);
    $display("step 2 defaults done: joystick_a=%h", joy_a);

    // 3: alternating pattern never settles; then a held pattern does.
    en_a = 1'b0;
    @(negedge clk);
    chk("disable_clears", joy_a, 24'h0);
    pat0_a = {12'hFFF, 12'hFFE}; pat1_a = {12'hFFF, 12'hFFD};
    s_fv = fvcnt_a;
    en_a = 1'b1;
    repeat (7180) @(negedge clk);
    chk("alt_no_fv", fvcnt_a - s_fv, 0);
    chk("alt_joystick", joy_a, 24'h0);
    pat0_a = {12'hFFF, 12'hFFD}; pat1_a = pat0_a;
    wait_fv(0, 6000, c);
    chk("hold_joystick", joy_a, 24'h000002);
    $display("step 3 debounce done: joystick_a=%h", joy_a);

    // 4: drop enable at bit 10 of SHIFT, then re-enable.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (idx_a == 10) begin found = 1; break; end
    end
    chk("reach_bit10", found, 1);
    repeat (30) @(negedge clk);
    chk("bit10_clk_low", jclk_a, 1'b0);
    s_fv = fvcnt_a;
    en_a = 1'b0;
    @(negedge clk);
    chk("drop_lines", {jclk_a, jload_a}, 2'b11);
    chk("drop_joystick", joy_a, 24'h0);
    pat0_a = {12'h7FF, 12'hFFF}; pat1_a = pat0_a;
    en_a = 1'b1;
    wait_load(0, 100, c);
    chk("reen_load_delay", c, 24);
    chk("drop_no_fv", fvcnt_a - s_fv, 0);
    wait_fv(0, 3000, c);
    chk("reen_fv_time", c, 2640);
    chk("reen_joystick", joy_a, 24'h800000);
    en_a = 1'b0;
    $display("step 4 enable drop done: joystick_a=%h", joy_a);

    // 5: active-high, 1x8, DEBOUNCE=1 -> updates every 27-tick frame.
    chain_b = 8'hA5;
    s_fv = fvcnt_b;
    en_b = 1'b1;
    wait_fv(1, 1000, c);
    chk("b_first_fv", c, 480);
    chk("b_joystick_a5", joy_b, 8'hA5);
    chain_b = 8'h1E;
    wait_fv(1, 1000, c);
    chk("b_period", c, 648);
    chk("b_joystick_1e", joy_b, 8'h1E);
    chk("b_fv_each_frame", fvcnt_b - s_fv, 2);
    en_b = 1'b0;
    $display("step 5 small config done: joystick_b=%h", joy_b);

    // 6: CLK_DIV=1, 1-clk reset mid-GAP, then normal restart.
    chain_c = 4'h0;
    en_c = 1'b1;
    wait_fv(2, 100, c);
    chk("c_first_fv", c, 31);
    chk("c_joystick", joy_c, 4'hF);
    repeat (2) @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    chk("c_rst_lines", {jclk_c, jload_c}, 2'b11);
    chk("c_rst_outputs", {joy_c, fv_c}, 5'h0);
    wait_load(1, 20, c);
    chk("c_restart_load", c, 1);
    wait_fv(2, 100, c);
    chk("c_restart_fv", c, 30);
    chk("c_restart_joystick", joy_c, 4'hF);
    $display("step 6 fast reset done: joystick_c=%h", joy_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
